// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply,
// valid/ready handshake on both sides with a held result register.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;

   typedef enum logic [3:0] {
      OP_AND = 4'd0, OP_OR  = 4'd1, OP_XOR = 4'd2,  OP_NOR = 4'd3,
      OP_ADD = 4'd4, OP_SUB = 4'd5, OP_SLT = 4'd6,  OP_SLTU = 4'd7,
      OP_SLL = 4'd8, OP_SRL = 4'd9, OP_SRA = 4'd10, OP_MUL = 4'd11
   } op_e;

   state_e           r_state;
   logic [WIDTH-1:0] r_out;
   logic             r_z, r_c, r_v;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [SHW-1:0]   r_cnt;

   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_sub;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_res;
   logic             w_c, w_v, w_z;
   logic [WIDTH-1:0] w_mul_next;

   assign w_add   = {1'b0, in1} + {1'b0, in2};
   assign w_sub   = {1'b0, in1} + {1'b0, ~in2} + (WIDTH+1)'(1);
   assign w_shamt = in2[SHW-1:0];

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (op)
         OP_AND:  w_res = in1 & in2;
         OP_OR:   w_res = in1 | in2;
         OP_XOR:  w_res = in1 ^ in2;
         OP_NOR:  w_res = ~(in1 | in2);
         OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_add[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_sub[WIDTH-1] != in1[WIDTH-1]);
         end
         OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
         OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
         OP_SLL:  w_res = in1 << w_shamt;
         OP_SRL:  w_res = in1 >> w_shamt;
         OP_SRA:  w_res = WIDTH'($signed(in1) >>> w_shamt);
         default: w_res = '0;
      endcase
      w_z = (w_res == '0);
   end

   assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   // HOLD frees the input side in the same cycle the result is consumed
   assign in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
   assign out_valid = r_out_valid;
   assign out       = r_out;
   assign flag_z    = r_z;
   assign flag_c    = r_c;
   assign flag_v    = r_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_out       <= '0;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
         r_v         <= 1'b0;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_HOLD: begin
               if (in_ready) begin
                  if (in_valid && (op == OP_MUL)) begin
                     r_state     <= S_MUL;
                     r_out_valid <= 1'b0;
                     r_acc       <= '0;
                     r_mcand     <= in1;
                     r_mplier    <= in2;
                     r_cnt       <= '0;
                  end else if (in_valid) begin
                     r_state     <= S_HOLD;
                     r_out_valid <= 1'b1;
                     r_out       <= w_res;
                     r_z         <= w_z;
                     r_c         <= w_c;
                     r_v         <= w_v;
                  end else begin
                     r_state     <= S_IDLE;
                     r_out_valid <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               r_acc    <= w_mul_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + SHW'(1);
               if (r_cnt == SHW'(WIDTH-1)) begin
                  r_state     <= S_HOLD;
                  r_out_valid <= 1'b1;
                  r_out       <= w_mul_next;
                  r_z         <= (w_mul_next == '0);
                  r_c         <= 1'b0;
                  r_v         <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Directed + random scoreboard bench for alu_mc at WIDTH=32.
module tb_alu_mc;

   localparam int W = 32;
   typedef logic [W+2:0] res_t;   // {out, z, c, v}

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]   op;
   logic [W-1:0] in1, in2, out;
   logic         flag_z, flag_c, flag_v;

   res_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
   );

   function automatic res_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic [63:0]  p;
      logic [4:0]   sh;
      logic         c, v;
      c = 1'b0; v = 1'b0; r = '0; sh = b[4:0];
      case (o)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: r = a ^ b;
         4'd3: r = ~(a | b);
         4'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                     v = ~(a[W-1] ^ b[W-1]) & (a[W-1] ^ r[W-1]); end
         4'd5: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[W-1:0]; c = s[W];
                     v = (a[W-1] ^ b[W-1]) & (a[W-1] ^ r[W-1]); end
         4'd6: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         4'd7: r = (a < b) ? 32'd1 : 32'd0;
         4'd8: r = a << sh;
         4'd9: r = a >> sh;
         4'd10: r = (a >> sh) | (a[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         4'd11: begin p = 64'(a) * 64'(b); r = p[W-1:0]; end
         default: r = '0;
      endcase
      return {r, (r == '0), c, v};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input res_t e);
      op = o; in1 = a; in2 = b; in_valid = 1'b1;
      chk("ready_at_send", in_ready, 1);
      exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic cmp_pop(input string tag);
      res_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_out"}, out, e[W+2:3]);
      chk({tag, "_z"}, flag_z, e[2]);
      chk({tag, "_c"}, flag_c, e[1]);
      chk({tag, "_v"}, flag_v, e[0]);
   endtask

   task automatic recv(input string tag, input int budget);
      int n = 0;
      while (out_valid !== 1'b1 && n < budget) begin tick(); n++; end
      cmp_pop(tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]   ro;
      logic [W-1:0] ra, rb, xr;
      int           busy;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; in1 = '0; in2 = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out", out, 0);
      chk("rst_flags", {flag_z, flag_c, flag_v}, 0);

      // arithmetic corners, 1-cycle latency enforced by budget 0
      send(4'd4, 32'hFFFF_FFFF, 32'h1, {32'h0, 1'b1, 1'b1, 1'b0});            recv("add_wrap", 0);
      send(4'd4, 32'h7FFF_FFFF, 32'h1, {32'h8000_0000, 1'b0, 1'b0, 1'b1});    recv("add_ovf", 0);
      send(4'd5, 32'd5, 32'd7, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});            recv("sub_borrow", 0);
      send(4'd6, 32'hFFFF_FFFF, 32'h1, {32'h1, 1'b0, 1'b0, 1'b0});            recv("slt", 0);
      send(4'd7, 32'hFFFF_FFFF, 32'h1, {32'h0, 1'b1, 1'b0, 1'b0});            recv("sltu", 0);
      send(4'd10, 32'h8000_0000, 32'h24, {32'hF800_0000, 1'b0, 1'b0, 1'b0}); recv("sra", 0);
      send(4'd9, 32'h8000_0000, 32'h24, {32'h0800_0000, 1'b0, 1'b0, 1'b0});  recv("srl", 0);
      send(4'd13, 32'h1234, 32'h5678, {32'h0, 1'b1, 1'b0, 1'b0});            recv("illegal", 0);

      // multiply latency
      send(4'd11, 32'h0001_0003, 32'h0002_0005, {32'h000B_000F, 1'b0, 1'b0, 1'b0});
      busy = 0;
      for (int k = 1; k <= 32; k++) begin
         if (in_ready === 1'b0 && out_valid === 1'b0) busy++;
         tick();
      end
      chk("mul_busy_cycles", busy, 32);
      recv("mul", 0);

      // back-to-back then stall
      out_ready = 1'b1; in_valid = 1'b1;
      op = 4'd0; in1 = 32'hF0F0_F0F0; in2 = 32'hFF00_FF00;
      exp_q.push_back(model(op, in1, in2));
      tick();
      cmp_pop("b2b_and");
      op = 4'd1;
      chk("b2b_ready1", in_ready, 1);
      exp_q.push_back(model(op, in1, in2));
      tick();
      cmp_pop("b2b_or");
      op = 4'd2;
      chk("b2b_ready2", in_ready, 1);
      exp_q.push_back(model(op, in1, in2));
      xr = 32'hF0F0_F0F0 ^ 32'hFF00_FF00;
      tick();
      cmp_pop("b2b_xor");
      out_ready = 1'b0; op = 4'd4; in1 = 32'd1; in2 = 32'd1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_out", out, xr);
         chk("stall_valid", out_valid, 1);
         chk("stall_ready", in_ready, 0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("drain_idle", out_valid, 0);

      // random ops, including illegal opcodes and wide shift amounts
      for (int i = 0; i < 24; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom; rb = $urandom;
         if (i % 6 == 0) ro = 4'd11;
         send(ro, ra, rb, model(ro, ra, rb));
         recv("rand", (ro == 4'd11) ? 40 : 0);
      end

      // reset in the middle of a multiply
      send(4'd11, 32'h1234_5678, 32'h9ABC_DEF1, model(4'd11, 32'h1234_5678, 32'h9ABC_DEF1));
      for (int k = 0; k < 9; k++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      chk("mulrst_valid", out_valid, 0);
      chk("mulrst_ready", in_ready, 1);
      chk("mulrst_out", out, 0);
      busy = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid !== 1'b0) busy++;
         tick();
      end
      chk("mulrst_no_result", busy, 0);
      send(4'd4, 32'd2, 32'd3, {32'd5, 1'b0, 1'b0, 1'b0});
      recv("post_rst_add", 0);

      // reset wins over a simultaneous accept
      reset = 1'b1; in_valid = 1'b1; op = 4'd0; in1 = '0; in2 = '0;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("rstpri_valid0", out_valid, 0);
      tick();
      chk("rstpri_valid1", out_valid, 0);
      chk("rstpri_z", flag_z, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
